// File: rtl/spi_reg_pkg.sv
// Shared constants and FSM state type for the SPI register bank.
package spi_reg_pkg;

    localparam int FRAME_W = 16;
    localparam int ADDR_W  = 7;
    localparam int DATA_W  = 8;

    localparam int ADDR_EN_OUT_7_0  = 'h00;
    localparam int ADDR_EN_OUT_15_8 = 'h01;
    localparam int ADDR_EN_PWM_7_0  = 'h02;
    localparam int ADDR_EN_PWM_15_8 = 'h03;
    localparam int ADDR_PWM_DUTY    = 'h04;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous SPI pin, followed by a single
// history flop that yields one-clk rise/fall pulses.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_i};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-0 target oversampled on clk; 16-bit write frames update the PWM control registers.
// Define SPI_REG_READBACK_EN to add register readback on cipo_o.
//
//   state  | meaning
//   IDLE   | ncs high, waiting for a frame to start
//   SHIFT  | ncs low, shifting COPI on each sclk rise
//   COMMIT | one clk after ncs rise; valid write frames land in the register file
module spi_reg_bank #(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_REGS    = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ncs_i,
    input  logic       sclk_i,
    input  logic       copi_i,
    output logic       cipo_o,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       wr_strobe_o
);
    import spi_reg_pkg::*;

    localparam int                CNT_W    = 5;
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(FRAME_W + 1);

    logic ncs_s, ncs_rise, ncs_fall;
    logic sclk_s, sclk_rise, sclk_fall;
    logic copi_s, copi_rise, copi_fall;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .rst(rst), .async_i(ncs_i),
        .sync_o(ncs_s), .rise_o(ncs_rise), .fall_o(ncs_fall)
    );
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .async_i(sclk_i),
        .sync_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst(rst), .async_i(copi_i),
        .sync_o(copi_s), .rise_o(copi_rise), .fall_o(copi_fall)
    );

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FRAME_W-1:0] sr_q, sr_d;
    logic [DATA_W-1:0]  regs_q [NUM_REGS];
    logic [DATA_W-1:0]  regs_d [NUM_REGS];
    logic               wr_strobe_q, wr_strobe_d;

    logic [ADDR_W-1:0]  frame_addr;
    logic [DATA_W-1:0]  frame_data;
    logic               frame_ok;

    assign frame_addr = sr_q[FRAME_W-2 -: ADDR_W];
    assign frame_data = sr_q[DATA_W-1:0];
    assign frame_ok   = (cnt_q == CNT_FULL) && sr_q[FRAME_W-1] &&
                        (frame_addr < ADDR_W'(NUM_REGS));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sr_d        = sr_q;
        regs_d      = regs_q;
        wr_strobe_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (ncs_fall) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    sr_d    = '0;
                end
            end
            SHIFT: begin
                // ncs rise takes priority over a coincident sclk rise
                if (ncs_rise) begin
                    state_d = COMMIT;
                end else if (sclk_rise) begin
                    sr_d = {sr_q[FRAME_W-2:0], copi_s};
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            COMMIT: begin
                if (frame_ok) begin
                    wr_strobe_d = 1'b1;
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (frame_addr == ADDR_W'(i)) begin
                            regs_d[i] = frame_data;
                        end
                    end
                end
                if (ncs_fall) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    sr_d    = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sr_q        <= '0;
            wr_strobe_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            wr_strobe_q <= wr_strobe_d;
            regs_q      <= regs_d;
        end
    end

    assign en_reg_out_7_0  = regs_q[ADDR_EN_OUT_7_0];
    assign en_reg_out_15_8 = regs_q[ADDR_EN_OUT_15_8];
    assign en_reg_pwm_7_0  = regs_q[ADDR_EN_PWM_7_0];
    assign en_reg_pwm_15_8 = regs_q[ADDR_EN_PWM_15_8];
    assign pwm_duty_cycle  = regs_q[ADDR_PWM_DUTY];
    assign wr_strobe_o     = wr_strobe_q;

`ifdef SPI_REG_READBACK_EN
    localparam logic [CNT_W-1:0] CNT_HDR_LAST = CNT_W'(ADDR_W);

    logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
    logic [3:0]        tx_cnt_q, tx_cnt_d;
    logic              cipo_q, cipo_d;
    logic [ADDR_W:0]   hdr;
    logic [ADDR_W-1:0] hdr_addr;

    always_comb begin
        tx_sr_d  = tx_sr_q;
        tx_cnt_d = tx_cnt_q;
        cipo_d   = cipo_q;
        hdr      = {sr_q[ADDR_W-1:0], copi_s};
        hdr_addr = hdr[ADDR_W-1:0];
        if (state_q != SHIFT || ncs_rise) begin
            tx_cnt_d = '0;
            cipo_d   = 1'b0;
        end else if (sclk_rise && cnt_q == CNT_HDR_LAST) begin
            // header complete on this edge; a valid read arms the output shifter
            if (!hdr[ADDR_W] && hdr_addr < ADDR_W'(NUM_REGS)) begin
                tx_cnt_d = 4'd8;
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (hdr_addr == ADDR_W'(i)) begin
                        tx_sr_d = regs_q[i];
                    end
                end
            end
        end else if (sclk_fall) begin
            if (tx_cnt_q != 4'd0) begin
                cipo_d   = tx_sr_q[DATA_W-1];
                tx_sr_d  = {tx_sr_q[DATA_W-2:0], 1'b0};
                tx_cnt_d = tx_cnt_q - 4'd1;
            end else begin
                cipo_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_sr_q  <= '0;
            tx_cnt_q <= '0;
            cipo_q   <= 1'b0;
        end else begin
            tx_sr_q  <= tx_sr_d;
            tx_cnt_q <= tx_cnt_d;
            cipo_q   <= cipo_d;
        end
    end

    assign cipo_o = cipo_q;

    logic unused_sync;
    assign unused_sync = ^{ncs_s, sclk_s, copi_rise, copi_fall};
`else
    assign cipo_o = 1'b0;

    logic unused_sync;
    assign unused_sync = ^{ncs_s, sclk_s, sclk_fall, copi_rise, copi_fall};
`endif

endmodule
